// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WWAIT  = 2'd1,
    SETUP  = 2'd2,
    ACCESS = 2'd3
  } state_t;

  localparam logic [31:0] BASE_ADDR    = 32'h8000_0000;
  localparam int          REGION_SHIFT = 26;
  localparam int          NUM_SLAVES   = 3;

  localparam logic [2:0] SEL_S0 = 3'b001;
  localparam logic [2:0] SEL_S1 = 3'b010;
  localparam logic [2:0] SEL_S2 = 3'b100;

endpackage

// File: rtl/apb_controller_if.sv
// Bus bundle between the AHB slave side, the APB side and the transfer sequencer.
interface apb_controller_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              valid;
  logic [ADDR_W-1:0] Haddr;
  logic              Hwrite;
  logic [DATA_W-1:0] Hwdata;
  logic [DATA_W-1:0] Prdata;
  logic              Hreadyout;
  logic [DATA_W-1:0] Hrdata;
  logic [2:0]        Pselx;
  logic              Penable;
  logic              Pwrite;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;

  // Sequencer view
  modport slave (
    input  valid, Haddr, Hwrite, Hwdata, Prdata,
    output Hreadyout, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata
  );

  // Driver view (AHB side plus APB read data)
  modport master (
    output valid, Haddr, Hwrite, Hwdata, Prdata,
    input  Hreadyout, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata
  );
endinterface

// File: rtl/apb_addr_decode.sv
// Combinational address decode: maps an AHB address to a one-hot APB select.
module apb_addr_decode #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(apb_bridge_pkg::BASE_ADDR),
  parameter int                REGION_SHIFT = apb_bridge_pkg::REGION_SHIFT
) (
  input  logic [ADDR_W-1:0] haddr,
  output logic              mapped,
  output logic [2:0]        sel
);

  // One extra bit carries the borrow, which flags addresses below the region.
  logic [ADDR_W:0]   diff_ext;
  logic              borrow;
  logic [ADDR_W-1:0] idx;

  assign diff_ext = {1'b0, haddr} - {1'b0, BASE_ADDR};
  assign borrow   = diff_ext[ADDR_W];
  assign idx      = diff_ext[ADDR_W-1:0] >> REGION_SHIFT;

  // Select the slave region; anything past the last slave stays unmapped.
  always_comb begin
    sel = 3'b000;
    if (!borrow) begin
      case (idx)
        ADDR_W'(0): sel = apb_bridge_pkg::SEL_S0;
        ADDR_W'(1): sel = apb_bridge_pkg::SEL_S1;
        ADDR_W'(2): sel = apb_bridge_pkg::SEL_S2;
        default:    sel = 3'b000;
      endcase
    end
    mapped = |sel;
  end

endmodule

// File: rtl/apb_controller.sv
// AHB-to-APB transfer sequencer: one transfer at a time, SETUP then ACCESS,
// AHB stretched through Hreadyout until the APB cycle finishes.
module apb_controller #(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(apb_bridge_pkg::BASE_ADDR),
  parameter int                REGION_SHIFT = apb_bridge_pkg::REGION_SHIFT
) (
  input  logic             Hclk,
  input  logic             Hreset,
  apb_controller_if.slave  bus
);

  apb_bridge_pkg::state_t state_reg;
  logic [2:0]        sel_reg;
  logic              hreadyout_reg;
  logic [2:0]        pselx_reg;
  logic              penable_reg;
  logic              pwrite_reg;
  logic [ADDR_W-1:0] paddr_reg;
  logic [DATA_W-1:0] pwdata_reg;
  logic [DATA_W-1:0] hrdata_reg;

  logic       dec_mapped;
  logic [2:0] dec_sel;

  apb_addr_decode #(
    .ADDR_W       (ADDR_W),
    .BASE_ADDR    (BASE_ADDR),
    .REGION_SHIFT (REGION_SHIFT)
  ) u_decode (
    .haddr  (bus.Haddr),
    .mapped (dec_mapped),
    .sel    (dec_sel)
  );

  // Sequencer FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_reg     <= apb_bridge_pkg::IDLE;
      sel_reg       <= 3'b000;
      hreadyout_reg <= 1'b1;
      pselx_reg     <= 3'b000;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      hrdata_reg    <= '0;
    end else begin
      case (state_reg)
        apb_bridge_pkg::IDLE: begin
          // Unmapped requests are silently dropped; the bus stays ready.
          if (bus.valid && dec_mapped) begin
            paddr_reg     <= bus.Haddr;
            pwrite_reg    <= bus.Hwrite;
            sel_reg       <= dec_sel;
            hreadyout_reg <= 1'b0;
            if (bus.Hwrite) begin
              state_reg <= apb_bridge_pkg::WWAIT;
            end else begin
              state_reg <= apb_bridge_pkg::SETUP;
              pselx_reg <= dec_sel;
            end
          end
        end
        apb_bridge_pkg::WWAIT: begin
          // Write data arrives one cycle after the address phase.
          pwdata_reg <= bus.Hwdata;
          pselx_reg  <= sel_reg;
          state_reg  <= apb_bridge_pkg::SETUP;
        end
        apb_bridge_pkg::SETUP: begin
          penable_reg <= 1'b1;
          state_reg   <= apb_bridge_pkg::ACCESS;
        end
        apb_bridge_pkg::ACCESS: begin
          // Zero-wait slaves: read data is valid during ACCESS.
          if (!pwrite_reg) begin
            hrdata_reg <= bus.Prdata;
          end
          pselx_reg     <= 3'b000;
          penable_reg   <= 1'b0;
          hreadyout_reg <= 1'b1;
          state_reg     <= apb_bridge_pkg::IDLE;
        end
        default: begin
          state_reg <= apb_bridge_pkg::IDLE;
        end
      endcase
    end
  end

  assign bus.Hreadyout = hreadyout_reg;
  assign bus.Hrdata    = hrdata_reg;
  assign bus.Pselx     = pselx_reg;
  assign bus.Penable   = penable_reg;
  assign bus.Pwrite    = pwrite_reg;
  assign bus.Paddr     = paddr_reg;
  assign bus.Pwdata    = pwdata_reg;

endmodule

// File: tb/tb_apb_controller.sv
// Self-checking bench: transaction-level reference model with randomized traffic.
module tb_apb_controller;

  logic Hclk;
  logic Hreset;

  apb_controller_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_controller #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .BASE_ADDR    (32'h8000_0000),
    .REGION_SHIFT (26)
  ) dut (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .bus    (bus)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  int total = 0;
  int bad   = 0;

  // Reference state: values the APB/AHB outputs should hold between transfers.
  logic [31:0] m_paddr;
  logic        m_pwrite;
  logic [31:0] m_pwdata;
  logic [31:0] m_hrdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Region decode straight from the address-map rule.
  function automatic void model_decode(input logic [31:0] a, output logic m, output logic [2:0] s);
    logic [31:0] idx;
    m = 1'b0;
    s = 3'b000;
    if (a >= 32'h8000_0000) begin
      idx = (a - 32'h8000_0000) >> 26;
      if (idx < 3) begin
        m = 1'b1;
        s = 3'(1 << idx);
      end
    end
  endfunction

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  // Random AHB activity presented while the controller is busy; must be ignored.
  task automatic noise();
    bus.valid  = 1'($urandom_range(0, 1));
    bus.Haddr  = 32'h8000_0000 + ($urandom_range(0, 2) << 26) + ($urandom & 32'h03FF_FFFC);
    bus.Hwrite = 1'($urandom_range(0, 1));
  endtask

  // One AHB transfer presented in an IDLE cycle, checked cycle by cycle.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input logic [31:0] rd, input bit rst_in_access);
    logic       m;
    logic [2:0] s;
    model_decode(a, m, s);
    chk("idle_rdy", bus.Hreadyout, 1);
    bus.valid  = 1'b1;
    bus.Haddr  = a;
    bus.Hwrite = w;
    bus.Prdata = $urandom;
    tick();
    if (!m) begin
      bus.valid = 1'b0;
      chk("unm_rdy", bus.Hreadyout, 1);
      chk("unm_sel", bus.Pselx, 0);
      chk("unm_pen", bus.Penable, 0);
      chk("unm_paddr", bus.Paddr, m_paddr);
      tick();
      chk("unm_rdy2", bus.Hreadyout, 1);
      chk("unm_sel2", bus.Pselx, 0);
      $display("xfer addr=%h unmapped ignored", a);
      return;
    end
    m_paddr  = a;
    m_pwrite = w;
    if (w) begin
      noise();
      bus.Hwdata = wd;
      chk("ww_rdy", bus.Hreadyout, 0);
      chk("ww_sel", bus.Pselx, 0);
      chk("ww_pen", bus.Penable, 0);
      chk("ww_paddr", bus.Paddr, m_paddr);
      chk("ww_pwrite", bus.Pwrite, 1);
      tick();
      m_pwdata   = wd;
      bus.Hwdata = $urandom;
    end
    noise();
    bus.Prdata = w ? $urandom : rd;
    chk("setup_sel", bus.Pselx, s);
    chk("setup_pen", bus.Penable, 0);
    chk("setup_rdy", bus.Hreadyout, 0);
    chk("setup_paddr", bus.Paddr, m_paddr);
    chk("setup_pwrite", bus.Pwrite, m_pwrite);
    chk("setup_pwdata", bus.Pwdata, m_pwdata);
    tick();
    noise();
    chk("acc_sel", bus.Pselx, s);
    chk("acc_pen", bus.Penable, 1);
    chk("acc_rdy", bus.Hreadyout, 0);
    chk("acc_hrdata", bus.Hrdata, m_hrdata);
    if (rst_in_access) begin
      Hreset = 1'b1;
      tick();
      Hreset    = 1'b0;
      bus.valid = 1'b0;
      m_paddr = 0; m_pwrite = 0; m_pwdata = 0; m_hrdata = 0;
      chk("rst_rdy", bus.Hreadyout, 1);
      chk("rst_sel", bus.Pselx, 0);
      chk("rst_pen", bus.Penable, 0);
      chk("rst_pwrite", bus.Pwrite, 0);
      chk("rst_paddr", bus.Paddr, 0);
      chk("rst_pwdata", bus.Pwdata, 0);
      chk("rst_hrdata", bus.Hrdata, 0);
      $display("xfer addr=%h write=%0d reset during ACCESS", a, w);
      return;
    end
    tick();
    bus.valid  = 1'b0;
    bus.Prdata = $urandom;
    if (!w) m_hrdata = rd;
    chk("done_rdy", bus.Hreadyout, 1);
    chk("done_sel", bus.Pselx, 0);
    chk("done_pen", bus.Penable, 0);
    chk("done_hrdata", bus.Hrdata, m_hrdata);
    chk("done_paddr", bus.Paddr, m_paddr);
    chk("done_pwrite", bus.Pwrite, m_pwrite);
    chk("done_pwdata", bus.Pwdata, m_pwdata);
    $display("xfer addr=%h write=%0d sel=%b wdata=%h hrdata=%h", a, w, s, m_pwdata, m_hrdata);
  endtask

  initial begin
    logic [31:0] a;
    logic        w;
    Hreset     = 1'b1;
    bus.valid  = 1'b0;
    bus.Haddr  = '0;
    bus.Hwrite = 1'b0;
    bus.Hwdata = '0;
    bus.Prdata = '0;
    tick();
    tick();
    chk("reset_rdy", bus.Hreadyout, 1);
    chk("reset_sel", bus.Pselx, 0);
    chk("reset_pen", bus.Penable, 0);
    chk("reset_pwrite", bus.Pwrite, 0);
    chk("reset_paddr", bus.Paddr, 0);
    chk("reset_pwdata", bus.Pwdata, 0);
    chk("reset_hrdata", bus.Hrdata, 0);
    m_paddr = 0; m_pwrite = 0; m_pwdata = 0; m_hrdata = 0;
    Hreset = 1'b0;
    tick();

    xfer(32'h8000_0010, 1'b0, 32'h0,          32'hDEAD_BEEF, 1'b0);
    xfer(32'h8400_0004, 1'b1, 32'h1234_5678,  32'h0,         1'b0);
    xfer(32'h8BFF_FFFC, 1'b0, 32'h0,          32'hA5A5_0F0F, 1'b0);
    xfer(32'h8C00_0000, 1'b0, 32'h0,          32'h1111_1111, 1'b0);
    xfer(32'h7FFF_FFFC, 1'b1, 32'h2222_2222,  32'h0,         1'b0);
    xfer(32'h8800_0000, 1'b1, 32'hCAFE_F00D,  32'h0,         1'b0);
    xfer(32'h8000_0000, 1'b0, 32'h0,          32'h5555_AAAA, 1'b0);
    xfer(32'h8400_0100, 1'b1, 32'h0BAD_C0DE,  32'h0,         1'b1);
    xfer(32'h8000_0020, 1'b0, 32'h0,          32'h7777_8888, 1'b0);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0, 1, 2: a = 32'h8000_0000 + ($urandom_range(0, 2) << 26) + ($urandom & 32'h03FF_FFFC);
        3:       a = 32'h8C00_0000 + ($urandom & 32'h3FFF_FFFC);
        default: a = $urandom & 32'h7FFF_FFFC;
      endcase
      w = 1'($urandom_range(0, 1));
      xfer(a, w, $urandom, $urandom, 1'b0);
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
